// File: rtl/imem_pkg.sv
// Shared types for the instruction-memory server.
// Response payload and its construction from a raw array word.
package imem_pkg;

  localparam int INSTR_W = 32;
  localparam logic [11:0] HALT_PATTERN = 12'h300;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        addr;
    logic               err;
    logic               halt;
  } imem_rsp_t;

  function automatic imem_rsp_t mk_rsp(
    input logic [INSTR_W-1:0] word,
    input logic [31:0]        addr,
    input logic               err
  );
    imem_rsp_t r;
    r.instr = err ? '0 : word;
    r.addr  = addr;
    r.err   = err;
    r.halt  = !err && (word[11:0] == HALT_PATTERN);
    return r;
  endfunction

endpackage

// File: rtl/imem_if.sv
// Fetch-side bus of the instruction-memory server.
// Master is the fetch unit / loader, slave is imem_server.
interface imem_if;
  import imem_pkg::*;

  logic               req_valid;
  logic               req_ready;
  logic [31:0]        req_addr;
  logic               flush;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [INSTR_W-1:0] rsp_instr;
  logic [31:0]        rsp_addr;
  logic               rsp_err;
  logic               rsp_halt;
  logic               ld_en;
  logic [31:0]        ld_addr;
  logic [31:0]        ld_data;

  modport master (
    output req_valid, req_addr, flush, rsp_ready,
    output ld_en, ld_addr, ld_data,
    input  req_ready, rsp_valid, rsp_instr,
    input  rsp_addr, rsp_err, rsp_halt
  );

  modport slave (
    input  req_valid, req_addr, flush, rsp_ready,
    input  ld_en, ld_addr, ld_data,
    output req_ready, rsp_valid, rsp_instr,
    output rsp_addr, rsp_err, rsp_halt
  );

endinterface

// File: rtl/imem_rsp_fifo.sv
// Response queue: DEPTH-entry synchronous FIFO of imem_rsp_t.
// Synchronous clear discards everything, including a same-cycle push.
module imem_rsp_fifo
  import imem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      clr_i,
  input  logic      push_i,
  input  imem_rsp_t data_i,
  input  logic      pop_i,
  output imem_rsp_t data_o,
  output logic      valid_o
);

  localparam int AW = $clog2(DEPTH);

  imem_rsp_t      mem_q [DEPTH];
  logic [AW:0]    wr_q, wr_d;
  logic [AW:0]    rd_q, rd_d;

  assign valid_o = (wr_q != rd_q);
  assign data_o  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    unique case (1'b1)
      clr_i: begin
        wr_d = '0;
        rd_d = '0;
      end
      default: begin
        if (push_i)
          wr_d = wr_q + (AW+1)'(1);
        if (pop_i && valid_o)
          rd_d = rd_q + (AW+1)'(1);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !clr_i)
      mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/imem_server.sv
// Instruction memory with fixed read latency and an in-order response queue.
// Holds the array, the read pipeline and the outstanding-request credit counter.
module imem_server
  import imem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  imem_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [INSTR_W-1:0] mem_q [2**ADDR_W];

  logic [CW-1:0]      cnt_q, cnt_d;
  logic               accept;
  logic               pop;
  logic               rd_err;
  logic [ADDR_W-1:0]  rd_idx;
  logic [INSTR_W-1:0] rd_word;
  imem_rsp_t          rd_rsp;
  logic               push;
  imem_rsp_t          push_rsp;
  imem_rsp_t          head;
  logic               head_v;
  logic               unused_ld;

  assign rd_idx  = bus.req_addr[ADDR_W+1:2];
  assign rd_err  = (|bus.req_addr[1:0]) ||
                   (|bus.req_addr[31:ADDR_W+2]);
  assign rd_word = rd_err ? '0 : mem_q[rd_idx];
  assign rd_rsp  = mk_rsp(rd_word, bus.req_addr, rd_err);

  // Credit is the registered count only; a pop frees a slot next cycle.
  assign bus.req_ready = (cnt_q < DEPTH_C) &&
                         !bus.flush && !bus.ld_en;
  assign accept = bus.req_valid && bus.req_ready;
  assign pop    = head_v && bus.rsp_ready;

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      bus.flush: cnt_d = '0;
      default:   cnt_d = cnt_q + CW'(accept) - CW'(pop);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    if (bus.ld_en)
      mem_q[bus.ld_addr[ADDR_W+1:2]] <= bus.ld_data;
  end

  assign unused_ld = ^{bus.ld_addr[1:0], bus.ld_addr[31:ADDR_W+2]};

  if (LATENCY == 1) begin : g_direct
    assign push     = accept;
    assign push_rsp = rd_rsp;
  end else begin : g_pipe
    localparam int S = LATENCY - 1;

    logic [S-1:0] pv_q, pv_d;
    imem_rsp_t    pd_q [S];

    always_comb begin
      pv_d = pv_q;
      if (bus.flush) begin
        pv_d = '0;
      end else begin
        pv_d[0] = accept;
        for (int i = 1; i < S; i++)
          pv_d[i] = pv_q[i-1];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        pv_q <= '0;
      else
        pv_q <= pv_d;
    end

    always_ff @(posedge clk) begin
      pd_q[0] <= rd_rsp;
      for (int i = 1; i < S; i++)
        pd_q[i] <= pd_q[i-1];
    end

    assign push     = pv_q[S-1];
    assign push_rsp = pd_q[S-1];
  end

  imem_rsp_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (bus.flush),
    .push_i  (push),
    .data_i  (push_rsp),
    .pop_i   (pop),
    .data_o  (head),
    .valid_o (head_v)
  );

  // Payload forced to zero while empty so reset/idle outputs are clean.
  assign bus.rsp_valid = head_v;
  assign bus.rsp_instr = head_v ? head.instr : '0;
  assign bus.rsp_addr  = head_v ? head.addr  : '0;
  assign bus.rsp_err   = head_v && head.err;
  assign bus.rsp_halt  = head_v && head.halt;

endmodule

// File: tb/tb_imem_server.sv
// Directed bench for imem_server: per-cycle vector table plus
// hand-written sequences for backpressure, flush and mid-run reset.
module tb_imem_server;
  import imem_pkg::*;

  localparam logic [31:0] W0  = 32'h20010005;
  localparam logic [31:0] W4  = 32'h00000300;
  localparam logic [31:0] W8A = 32'h11111111;
  localparam logic [31:0] W8B = 32'h22222222;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  imem_if bus();

  imem_server #(
    .ADDR_W  (10),
    .LATENCY (2),
    .DEPTH   (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        rv;
    logic [31:0] ra;
    logic        rr;
    logic        fl;
    logic        le;
    logic [31:0] la;
    logic [31:0] ld;
    logic        e_rdy;
    logic        e_v;
    logic [31:0] e_instr;
    logic [31:0] e_addr;
    logic        e_err;
    logic        e_halt;
  } vec_t;

  function automatic vec_t mk(
    input logic rv, input logic [31:0] ra, input logic rr,
    input logic fl, input logic le,
    input logic [31:0] la, input logic [31:0] ld,
    input logic e_rdy, input logic e_v,
    input logic [31:0] e_instr, input logic [31:0] e_addr,
    input logic e_err, input logic e_halt
  );
    vec_t v;
    v.rv = rv; v.ra = ra; v.rr = rr; v.fl = fl;
    v.le = le; v.la = la; v.ld = ld;
    v.e_rdy = e_rdy; v.e_v = e_v;
    v.e_instr = e_instr; v.e_addr = e_addr;
    v.e_err = e_err; v.e_halt = e_halt;
    return v;
  endfunction

  // Drive one cycle at the falling edge, check outputs 1ns later.
  task automatic apply(input vec_t v, input string nm);
    logic [67:0] g, e;
    bus.req_valid = v.rv;
    bus.req_addr  = v.ra;
    bus.rsp_ready = v.rr;
    bus.flush     = v.fl;
    bus.ld_en     = v.le;
    bus.ld_addr   = v.la;
    bus.ld_data   = v.ld;
    #1;
    g = {bus.req_ready, bus.rsp_valid, bus.rsp_instr,
         bus.rsp_addr, bus.rsp_err, bus.rsp_halt};
    e = {v.e_rdy, v.e_v, v.e_instr, v.e_addr, v.e_err, v.e_halt};
    if (!v.e_v) begin
      g[65:0] = '0;
      e[65:0] = '0;
    end
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL %s: got rdy=%b v=%b instr=%h addr=%h err=%b halt=%b exp rdy=%b v=%b instr=%h addr=%h err=%b halt=%b",
               nm, g[67], g[66], g[65:34], g[33:2], g[1], g[0],
               e[67], e[66], e[65:34], e[33:2], e[1], e[0]);
    end
    @(negedge clk);
  endtask

  task automatic cy(
    input string nm, input logic rv, input logic [31:0] ra,
    input logic rr, input logic fl, input logic e_rdy,
    input logic e_v, input logic [31:0] ei,
    input logic [31:0] ea, input logic eh
  );
    apply(mk(rv, ra, rr, fl, 1'b0, 32'h0, 32'h0,
             e_rdy, e_v, ei, ea, 1'b0, eh), nm);
  endtask

  task automatic chk_rst(input string nm);
    logic [66:0] g;
    g = {bus.rsp_valid, bus.rsp_instr, bus.rsp_addr,
         bus.rsp_err, bus.rsp_halt};
    checks++;
    if (g !== '0) begin
      failures++;
      $display("FAIL %s: got v=%b instr=%h addr=%h err=%b halt=%b exp all zero",
               nm, g[66], g[65:34], g[33:2], g[1], g[0]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  vec_t tbl[$];

  initial begin
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.rsp_ready = 1'b0;
    bus.flush     = 1'b0;
    bus.ld_en     = 1'b0;
    bus.ld_addr   = '0;
    bus.ld_data   = '0;

    // load + back-to-back fetch, error requests, read-before-write
    tbl.push_back(mk(0, 0, 1, 0, 1, 0, W0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 4, W4,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 8, W8A, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,   1, 1, W0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,   1, 1, W4, 4, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h1000, 1, 0, 0, 0, 0,
                     1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,   1, 1, 0, 2, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,
                     1, 1, 0, 32'h1000, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 1, 8, W8B, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8, 1, 0, 0, 0, 0,   1, 1, W8A, 8, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,   1, 1, W8B, 8, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0));

    repeat (2) @(negedge clk);
    #1;
    chk_rst("reset");
    @(negedge clk);
    rst_n = 1'b1;
    cy("post_reset", 0, 0, 0, 0, 1, 0, 0, 0, 0);

    foreach (tbl[i])
      apply(tbl[i], $sformatf("tbl%0d", i));

    // backpressure: 6 offered, 4 accepted, pop not credited same cycle
    cy("bp_req0", 1, 0, 0, 0, 1, 0, 0,   0, 0);
    cy("bp_req1", 1, 4, 0, 0, 1, 0, 0,   0, 0);
    cy("bp_req2", 1, 8, 0, 0, 1, 1, W0,  0, 0);
    cy("bp_req3", 1, 0, 0, 0, 1, 1, W0,  0, 0);
    cy("bp_req4", 1, 4, 0, 0, 0, 1, W0,  0, 0);
    cy("bp_req5", 1, 8, 0, 0, 0, 1, W0,  0, 0);
    cy("bp_pop0", 0, 0, 1, 0, 0, 1, W0,  0, 0);
    cy("bp_pop1", 0, 0, 1, 0, 1, 1, W4,  4, 1);
    cy("bp_pop2", 0, 0, 1, 0, 1, 1, W8B, 8, 0);
    cy("bp_pop3", 0, 0, 1, 0, 1, 1, W0,  0, 0);
    cy("bp_empty", 0, 0, 1, 0, 1, 0, 0,  0, 0);

    // flush with 3 outstanding, then refill to prove count cleared
    cy("fl_req0", 1, 0, 0, 0, 1, 0, 0,   0, 0);
    cy("fl_req1", 1, 4, 0, 0, 1, 0, 0,   0, 0);
    cy("fl_req2", 1, 8, 0, 0, 1, 1, W0,  0, 0);
    cy("fl_flush", 1, 4, 1, 1, 0, 1, W0, 0, 0);
    cy("fl_after0", 0, 0, 1, 0, 1, 0, 0, 0, 0);
    cy("fl_after1", 0, 0, 1, 0, 1, 0, 0, 0, 0);
    cy("fl_after2", 0, 0, 1, 0, 1, 0, 0, 0, 0);
    cy("fl_after3", 0, 0, 1, 0, 1, 0, 0, 0, 0);
    cy("fl_new", 1, 8, 1, 0, 1, 0, 0,    0, 0);
    cy("fl_new_w", 0, 0, 1, 0, 1, 0, 0,  0, 0);
    cy("fl_new_rsp", 0, 0, 1, 0, 1, 1, W8B, 8, 0);
    cy("fl_new_end", 0, 0, 1, 0, 1, 0, 0,   0, 0);
    cy("cnt_req0", 1, 0, 0, 0, 1, 0, 0,  0, 0);
    cy("cnt_req1", 1, 4, 0, 0, 1, 0, 0,  0, 0);
    cy("cnt_req2", 1, 0, 0, 0, 1, 1, W0, 0, 0);
    cy("cnt_req3", 1, 4, 0, 0, 1, 1, W0, 0, 0);
    cy("cnt_full", 1, 0, 0, 0, 0, 1, W0, 0, 0);
    cy("fl_full", 0, 0, 0, 1, 0, 1, W0,  0, 0);
    cy("fl_full_after", 0, 0, 1, 0, 1, 0, 0, 0, 0);
    cy("fl_idle", 0, 0, 1, 1, 0, 0, 0,   0, 0);
    cy("fl_idle_req", 1, 4, 1, 0, 1, 0, 0, 0, 0);
    cy("fl_idle_w", 0, 0, 1, 0, 1, 0, 0, 0, 0);
    cy("fl_idle_rsp", 0, 0, 1, 0, 1, 1, W4, 4, 1);
    cy("fl_idle_end", 0, 0, 1, 0, 1, 0, 0,  0, 0);

    // reset with two queued responses
    cy("rst_req0", 1, 0, 0, 0, 1, 0, 0,  0, 0);
    cy("rst_req1", 1, 4, 0, 0, 1, 0, 0,  0, 0);
    cy("rst_hold", 0, 0, 0, 0, 1, 1, W0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk_rst("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++)
      cy($sformatf("rst_after%0d", i), 0, 0, 1, 0, 1, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
